// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a single shared WIDTH-bit register.
// Grants one requester, commits its data with an ack pulse, then holds off for a guard window.
module reg_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] d_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_bar,
  output logic [2:0]               owner,
  output logic                     busy
);

  localparam int         CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [2:0] OWNER_RST = 3'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

  state_t             r_state, w_state_next;
  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [NUM_REQ-1:0] r_ack, w_ack_next;
  logic [WIDTH-1:0]   r_q, w_q_next;
  logic [2:0]         r_owner, w_owner_next;
  logic               r_busy, w_busy_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;

  logic [WIDTH-1:0]   w_d [NUM_REQ];
  logic [NUM_REQ-1:0] w_owner_oh;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_REQ-1:0] w_rot;
  logic [3:0]         w_rot_amt;
  logic [3:0]         w_sum;
  logic [2:0]         w_win;
  logic               w_req_owner;
  logic [WIDTH-1:0]   w_owner_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_d[gi]        = d_in[gi*WIDTH +: WIDTH];
      assign w_owner_oh[gi] = (r_owner == 3'(gi));
      assign w_win_oh[gi]   = (w_win == 3'(gi));
    end
  endgenerate

  // Rotate the request vector so bit 0 is the requester just after the current owner.
  assign w_rot_amt = {1'b0, r_owner} + 4'd1;
  assign w_rot     = NUM_REQ'({req, req} >> w_rot_amt);

  always_comb begin
    w_sum = 4'd0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_sum = w_rot_amt + 4'(j);
    end
    if (w_sum >= 4'(NUM_REQ)) w_sum = w_sum - 4'(NUM_REQ);
    w_win = w_sum[2:0];
  end

  always_comb begin
    w_owner_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_owner_d = w_owner_d | (w_d[i] & {WIDTH{w_owner_oh[i]}});
    end
    w_req_owner = |(req & w_owner_oh);
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = '0;
    w_ack_next   = '0;
    w_q_next     = r_q;
    w_owner_next = r_owner;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req != '0) begin
          w_state_next = S_GRANT;
          w_grant_next = w_win_oh;
          w_owner_next = w_win;
        end
      end
      S_GRANT: begin
        // A withdrawn request aborts, but owner keeps the aborted index so priority still moves on.
        if (w_req_owner) begin
          w_q_next     = w_owner_d;
          w_ack_next   = w_owner_oh;
          w_cnt_next   = CNT_LOAD;
          w_state_next = S_HOLD;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) w_state_next = S_IDLE;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ack   <= '0;
      r_q     <= '0;
      r_owner <= OWNER_RST;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_ack   <= w_ack_next;
      r_q     <= w_q_next;
      r_owner <= w_owner_next;
      r_busy  <= w_busy_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign grant = r_grant;
  assign ack   = r_ack;
  assign q     = r_q;
  assign q_bar = ~r_q;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected commits are queued when driven
// and matched against each ack; protocol invariants are watched every cycle.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   d_in;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic [W-1:0]     q;
  logic [W-1:0]     q_bar;
  logic [2:0]       owner;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int m_owner;
  logic [10:0] sb_q[$];

  reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .d_in(d_in),
    .grant(grant), .ack(ack), .q(q), .q_bar(q_bar), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Per-cycle invariants and scoreboard matching on every ack pulse.
  always @(negedge clk) begin
    checks++;
    if ($countones(grant) > 1 || $countones(ack) > 1 || (grant != '0 && ack != '0)) begin
      errors++;
      $display("FAIL onehot: grant=%b ack=%b required one-hot and not overlapping", grant, ack);
    end
    if (ack != '0) begin
      logic [10:0] e;
      logic [N-1:0] e_oh;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: ack=%b q=%h required no ack", ack, q);
      end else begin
        e = sb_q.pop_front();
        e_oh = N'(1) << e[10:8];
        $display("txn: ack=%b q=%h expected req%0d data=%h", ack, q, e[10:8], e[7:0]);
        if (ack !== e_oh || q !== e[7:0] || q_bar !== ~e[7:0]) begin
          errors++;
          $display("FAIL sb_commit: ack=%b q=%h q_bar=%h required ack=%b q=%h q_bar=%h",
                   ack, q, q_bar, e_oh, e[7:0], ~e[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_d(input int i, input logic [W-1:0] v);
    d_in[i*W +: W] = v;
  endtask

  function automatic int pick(input int own, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(own + k) % N]) return (own + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_owner = N - 1;
  endtask

  task automatic test_reset();
    req = '0;
    d_in = '0;
    do_reset();
    checks++; if (q !== 8'h00)   begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_qbar: got %h want FF", q_bar); end
    checks++; if (grant !== '0)  begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (ack !== '0)    begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (owner !== 3'd3) begin errors++; $display("FAIL reset_owner: got %0d want 3", owner); end
  endtask

  task automatic test_single();
    req = 4'b0100;
    set_d(2, 8'hA5);
    sb_q.push_back({3'd2, 8'hA5});
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
    checks++; if (owner !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL single_owner: got owner=%0d busy=%b want 2/1", owner, busy); end
    step();
    checks++; if (ack !== 4'b0100 || grant !== '0) begin errors++; $display("FAIL single_ack: got ack=%b grant=%b want 0100/0000", ack, grant); end
    checks++; if (q !== 8'hA5 || q_bar !== 8'h5A) begin errors++; $display("FAIL single_q: got q=%h q_bar=%h want A5/5A", q, q_bar); end
    req = '0;
    step();
    checks++; if (ack !== '0 || busy !== 1'b1) begin errors++; $display("FAIL single_hold: got ack=%b busy=%b want 0000/1", ack, busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    m_owner = 2;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int last = 0;
    int budget;
    do_reset();
    for (int i = 0; i < N; i++) set_d(i, 8'h10 + 8'(i));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      budget = 0;
      do begin
        step();
        budget++;
      end while (grant === '0 && budget < 12);
      checks++;
      if (grant !== (N'(1) << exp_order[n])) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", n, grant, N'(1) << exp_order[n]);
      end
      if (n > 0) begin
        checks++;
        if (cyc - last != 4) begin errors++; $display("FAIL rr_spacing%0d: got %0d want 4", n, cyc - last); end
      end
      last = cyc;
      sb_q.push_back({3'(exp_order[n]), 8'h10 + 8'(exp_order[n])});
      step();
      checks++;
      if (q !== 8'h10 + 8'(exp_order[n])) begin
        errors++;
        $display("FAIL rr_q%0d: got %h want %h", n, q, 8'h10 + 8'(exp_order[n]));
      end
      if (n == 4) req = '0;
    end
    step(); step(); step();
    m_owner = 0;
  endtask

  task automatic test_abort();
    logic [W-1:0] q_before;
    int w;
    do_reset();
    q_before = q;
    req = 4'b0010;
    set_d(1, 8'h77);
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL abort_grant: got %b want 0010", grant); end
    req = '0;
    step();
    checks++; if (ack !== '0 || grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got ack=%b grant=%b busy=%b want 0/0/0", ack, grant, busy); end
    checks++; if (q !== q_before) begin errors++; $display("FAIL abort_q: got %h want %h", q, q_before); end
    m_owner = 1;
    req = 4'b0011;
    set_d(0, 8'h20);
    set_d(1, 8'h21);
    w = pick(m_owner, req);
    sb_q.push_back({3'(w), 8'h20});
    step();
    checks++; if (grant !== 4'b0001 || w != 0) begin errors++; $display("FAIL abort_wrap: got %b want 0001", grant); end
    step();
    req = '0;
    step(); step();
    m_owner = 0;
  endtask

  task automatic test_reset_in_hold();
    req = 4'b0100;
    set_d(2, 8'h3C);
    sb_q.push_back({3'd2, 8'h3C});
    step();
    step();
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL rih_write: got %h want 3C", q); end
    req = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (q !== 8'h00 || q_bar !== 8'hFF) begin errors++; $display("FAIL rih_q: got q=%h q_bar=%h want 00/FF", q, q_bar); end
    checks++; if (busy !== 1'b0 || ack !== '0 || grant !== '0) begin errors++; $display("FAIL rih_ctrl: got busy=%b ack=%b grant=%b want 0", busy, ack, grant); end
    checks++; if (owner !== 3'd3) begin errors++; $display("FAIL rih_owner: got %0d want 3", owner); end
    m_owner = 3;
  endtask

  task automatic test_mid_hold();
    int w;
    req = 4'b0001;
    set_d(0, 8'h55);
    sb_q.push_back({3'd0, 8'h55});
    step();
    step();
    m_owner = 0;
    req = 4'b1000;
    set_d(3, 8'h66);
    step();
    checks++; if (grant !== '0 || busy !== 1'b1) begin errors++; $display("FAIL midhold_wait1: got grant=%b busy=%b want 0000/1", grant, busy); end
    step();
    checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL midhold_wait2: got grant=%b busy=%b want 0000/0", grant, busy); end
    w = pick(m_owner, req);
    sb_q.push_back({3'(w), 8'h66});
    step();
    checks++; if (grant !== (N'(1) << w)) begin errors++; $display("FAIL midhold_grant: got %b want %b", grant, N'(1) << w); end
    step();
    req = '0;
    step(); step(); step();
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    d_in = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_reset_in_hold();
    test_mid_hold();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending commits want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
